// File: rtl/sdram_arb.sv
`timescale 1ns/1ps
// sdram_arb: arbitrates a write stream, a read stream and refresh requests
// onto a single SDRAM controller command port. Bursts are bounded by
// BURST_LEN and every burst or refresh passes through IDLE before the next
// owner is chosen, so refresh latency is bounded by one burst plus drain.
//
// state | meaning
// IDLE  | no owner; pick next owner (refresh > write/read fairness rule)
// WR    | write burst, one word per accepted command
// RD    | read burst, issue up to BURST_LEN commands, drain all returns
// REF   | refresh command pending until the controller accepts it
module sdram_arb #(
  parameter int BURST_LEN = 16
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_prio,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_cmd_ack,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  input  logic        ref_req,
  output logic        ref_ack,
  output logic        mem_cmd_valid,
  output logic        mem_cmd_we,
  output logic        mem_cmd_ref,
  output logic [31:0] mem_cmd_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_cmd_ready,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  grant
);

  // One extra bit so the counters can hold BURST_LEN itself.
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] BL_FULL = CW'(BURST_LEN);
  localparam logic [CW-1:0] BL_LAST = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_REF  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [CW-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [CW-1:0] outst_q, outst_d;
  logic          last_rd_q, last_rd_d;   // 1: read stream owned the last burst
  logic          ref_ack_q, ref_ack_d;

  // Next-state decision, burst bookkeeping and command-port muxing.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    cmd_cnt_d     = cmd_cnt_q;
    outst_d       = outst_q;
    last_rd_d     = last_rd_q;
    ref_ack_d     = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_ref   = 1'b0;
    mem_cmd_addr  = '0;
    mem_wdata     = '0;
    wr_valid      = 1'b0;
    rd_cmd_ack    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        beat_d    = '0;
        cmd_cnt_d = '0;
        if (ref_req) begin
          state_d = S_REF;
        end else if (wr_req && (wr_prio || !rd_req || last_rd_q)) begin
          state_d = S_WR;
        end else if (rd_req) begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        mem_cmd_valid = wr_req;
        mem_cmd_we    = 1'b1;
        mem_cmd_addr  = wr_addr;
        mem_wdata     = wr_data;
        wr_valid      = wr_req & mem_cmd_ready;
        if (wr_valid) begin
          beat_d = beat_q + CW'(1);
        end
        if (!wr_req || (wr_valid && beat_q == BL_LAST)) begin
          state_d   = S_IDLE;
          beat_d    = '0;
          last_rd_d = 1'b0;
        end
      end
      S_RD: begin
        mem_cmd_valid = rd_req && (cmd_cnt_q < BL_FULL);
        mem_cmd_addr  = rd_addr;
        rd_cmd_ack    = mem_cmd_valid & mem_cmd_ready;
        if (rd_cmd_ack) begin
          cmd_cnt_d = cmd_cnt_q + CW'(1);
        end
        // A return with nothing in flight is a stray and must not underflow.
        if (rd_cmd_ack && !mem_rvalid) begin
          outst_d = outst_q + CW'(1);
        end else if (!rd_cmd_ack && mem_rvalid && outst_q != '0) begin
          outst_d = outst_q - CW'(1);
        end
        if (outst_q == '0 && (cmd_cnt_q == BL_FULL || !rd_req)) begin
          state_d   = S_IDLE;
          cmd_cnt_d = '0;
          last_rd_d = 1'b1;
        end
      end
      S_REF: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_ref   = 1'b1;
        if (mem_cmd_ready) begin
          ref_ack_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      cmd_cnt_q <= '0;
      outst_q   <= '0;
      last_rd_q <= 1'b1;
      ref_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cmd_cnt_q <= cmd_cnt_d;
      outst_q   <= outst_d;
      last_rd_q <= last_rd_d;
      ref_ack_q <= ref_ack_d;
    end
  end

  // Read returns only pass through while a read burst owns the port.
  always_comb begin
    rd_valid = mem_rvalid && (state_q == S_RD);
    rd_data  = rd_valid ? mem_rdata : '0;
    ref_ack  = ref_ack_q;
    grant    = state_q;
  end

endmodule

// File: tb/tb_sdram_arb.sv
`timescale 1ns/1ps
// tb_sdram_arb: phased random stimulus against a cycle-level behavioural
// model of the arbitration rules, with a small in-order read-return memory.
module tb_sdram_arb;

  localparam int BL = 4;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst;
  logic        wr_req, wr_prio, rd_req, ref_req;
  logic [31:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_valid, rd_cmd_ack, rd_valid, ref_ack;
  logic [15:0] rd_data;
  logic        mem_cmd_valid, mem_cmd_we, mem_cmd_ref;
  logic [31:0] mem_cmd_addr;
  logic [15:0] mem_wdata;
  logic        mem_cmd_ready, mem_rvalid;
  logic [15:0] mem_rdata;
  logic [1:0]  grant;

  sdram_arb #(.BURST_LEN(BL)) dut (
    .sdram_clk    (sdram_clk),
    .sdram_rst    (sdram_rst),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_prio      (wr_prio),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_cmd_ack   (rd_cmd_ack),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .ref_req      (ref_req),
    .ref_ack      (ref_ack),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_we   (mem_cmd_we),
    .mem_cmd_ref  (mem_cmd_ref),
    .mem_cmd_addr (mem_cmd_addr),
    .mem_wdata    (mem_wdata),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .grant        (grant)
  );

  // 100 MHz clock.
  always #5 sdram_clk = ~sdram_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner 0 none, 1 write, 2 read, 3 refresh.
  int m_owner, m_words, m_issued, m_inflight, m_last, m_ack;

  task automatic model_reset();
    m_owner    = 0;
    m_words    = 0;
    m_issued   = 0;
    m_inflight = 0;
    m_last     = 2;
    m_ack      = 0;
  endtask

  typedef struct {
    int n;        // cycles
    int p_wr;     // % wr_req
    int p_rd;     // % rd_req
    int prio;     // 0, 1, 2 = random
    int p_ready;  // % mem_cmd_ready
    int p_ref;    // % new refresh request
    int lat;      // read latency, 0 = random 1..5
    int p_rst;    // per-mille reset
    bit rst_out2; // one reset while two reads are in flight
  } phase_t;

  phase_t ph[8];
  int     rq[$];
  int     last_due, cyc, due, lat;
  bit     ref_pend, shot, rst_prev, leave;
  int     prev_g, new_rd;
  logic   e_wv, e_v, e_we, e_rf, e_ack, e_rv;
  logic [31:0] e_addr;
  logic [15:0] e_wd, e_rd;

  initial begin
    ph[0] = '{20,   100, 0,   0, 100, 0, 2, 0, 1'b0};  // write stream
    ph[1] = '{60,   100, 100, 0, 100, 0, 2, 0, 1'b0};  // fair alternation
    ph[2] = '{40,   100, 100, 1, 100, 0, 2, 0, 1'b0};  // write priority
    ph[3] = '{40,   0,   100, 0, 100, 0, 3, 0, 1'b0};  // read stream, latency 3
    ph[4] = '{60,   100, 40,  2, 100, 8, 0, 0, 1'b0};  // refresh mid-burst
    ph[5] = '{120,  90,  60,  2, 50,  5, 0, 0, 1'b0};  // command stalls
    ph[6] = '{60,   0,   100, 0, 100, 0, 3, 0, 1'b1};  // reset with reads in flight
    ph[7] = '{3000, 70,  70,  2, 70,  3, 0, 5, 1'b0};  // everything random

    sdram_rst = 1'b1;
    wr_req = 1'b0; wr_prio = 1'b0; rd_req = 1'b0; ref_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    mem_cmd_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge sdram_clk);
    model_reset();
    last_due = 0; cyc = 0; ref_pend = 1'b0; rst_prev = 1'b1;

    for (int p = 0; p < 8; p++) begin
      prev_g = 3; new_rd = 0; shot = 1'b0;
      for (int c = 0; c < ph[p].n; c++) begin
        @(posedge sdram_clk);
        #1;
        if (m_ack != 0) ref_pend = 1'b0;
        sdram_rst = (($urandom % 1000) < 32'(ph[p].p_rst)) ||
                    (ph[p].rst_out2 && !shot && m_owner == 2 && m_inflight == 2);
        if (ph[p].rst_out2 && sdram_rst) shot = 1'b1;
        wr_req  = ($urandom % 100) < 32'(ph[p].p_wr);
        rd_req  = ($urandom % 100) < 32'(ph[p].p_rd);
        wr_prio = (ph[p].prio == 2) ? 1'($urandom % 2) : (ph[p].prio == 1);
        if (!ref_pend && (($urandom % 100) < 32'(ph[p].p_ref))) ref_pend = 1'b1;
        ref_req       = ref_pend;
        mem_cmd_ready = ($urandom % 100) < 32'(ph[p].p_ready);
        wr_addr   = $urandom;
        rd_addr   = $urandom;
        wr_data   = 16'($urandom);
        mem_rdata = 16'($urandom);
        if (rq.size() > 0 && rq[0] <= cyc) begin
          void'(rq.pop_front());
          mem_rvalid = 1'b1;
        end else begin
          mem_rvalid = (rq.size() == 0) && (m_owner != 2) && (($urandom % 16) == 0);
        end

        // Expected outputs for this cycle.
        e_wv = 1'b0; e_v = 1'b0; e_we = 1'b0; e_rf = 1'b0; e_ack = 1'b0;
        e_addr = '0; e_wd = '0;
        if (m_owner == 1) begin
          e_v = wr_req; e_we = 1'b1; e_addr = wr_addr; e_wd = wr_data;
          e_wv = wr_req && mem_cmd_ready;
        end else if (m_owner == 2) begin
          e_v = rd_req && (m_issued < BL); e_addr = rd_addr;
          e_ack = e_v && mem_cmd_ready;
        end else if (m_owner == 3) begin
          e_v = 1'b1; e_rf = 1'b1;
        end
        e_rv = mem_rvalid && (m_owner == 2);
        e_rd = e_rv ? mem_rdata : 16'h0;

        @(negedge sdram_clk);
        chk_eq("grant", 32'(grant), 32'(m_owner));
        chk_eq("ctl", 32'({wr_valid, mem_cmd_valid, mem_cmd_we, mem_cmd_ref, rd_cmd_ack, rd_valid, ref_ack}),
                      32'({e_wv, e_v, e_we, e_rf, e_ack, e_rv, (m_ack != 0)}));
        chk_eq("addr", mem_cmd_addr, e_addr);
        chk_eq("wdata", 32'(mem_wdata), 32'(e_wd));
        chk_eq("rdata", 32'(rd_data), 32'(e_rd));
        if (rst_prev) begin
          chk_eq("rst_outs", 32'({grant, wr_valid, rd_cmd_ack, rd_valid, ref_ack, mem_cmd_valid,
                                  mem_cmd_we, mem_cmd_ref, |mem_cmd_addr, |mem_wdata, |rd_data}), 32'd0);
        end
        if (grant == 2'd2 && prev_g == 0) new_rd++;
        prev_g   = int'(grant);
        rst_prev = sdram_rst;

        // Memory schedules an in-order return for each accepted read.
        if (e_ack) begin
          lat = (ph[p].lat == 0) ? int'($urandom_range(1, 5)) : ph[p].lat;
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          rq.push_back(due);
          last_due = due;
        end

        // Advance the model by one clock.
        if (sdram_rst) begin
          model_reset();
        end else begin
          leave = 1'b0;
          m_ack = (m_owner == 3 && mem_cmd_ready) ? 1 : 0;
          case (m_owner)
            0: begin
              if (ref_req) m_owner = 3;
              else if (wr_req && (wr_prio || !rd_req || m_last == 2)) m_owner = 1;
              else if (rd_req) m_owner = 2;
            end
            1: begin
              if (e_wv) m_words++;
              if (!wr_req || m_words == BL) begin
                m_owner = 0; m_words = 0; m_last = 1;
              end
            end
            2: begin
              leave = (m_inflight == 0) && (m_issued == BL || !rd_req);
              if (e_ack) m_issued++;
            end
            default: if (mem_cmd_ready) m_owner = 0;
          endcase
          m_inflight = m_inflight + (e_ack ? 1 : 0) - (mem_rvalid ? 1 : 0);
          if (m_inflight < 0) m_inflight = 0;
          if (leave) begin
            m_owner = 0; m_issued = 0; m_last = 2;
          end
        end
        cyc++;
      end
      if (p == 2) chk_eq("prio_no_rd", 32'(new_rd), 32'd0);
      if (p == 6) chk_eq("rst_fired", 32'(shot), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter BURST_LEN, default 16: maximum words granted per burst; legal range 2..64.
REQ-002 sdram_clk  in  1  sole clock; every register updates on its rising edge.
REQ-003 sdram_rst  in  1  reset, synchronous and active-high.
REQ-004 wr_req  in  1  write requester has a word ready (write FIFO not empty).
REQ-005 wr_addr  in  32  write word address.
REQ-006 wr_data  in  16  write word.
REQ-007 wr_valid  out  1  write word accepted this cycle (FIFO read strobe).
REQ-008 wr_prio  in  1  capture active; the write requester wins every contended IDLE decision.
REQ-009 rd_req  in  1  read requester wants another word.
REQ-010 rd_addr  in  32  read word address.
REQ-011 rd_cmd_ack  out  1  read command accepted this cycle (requester advances rd_addr).
REQ-012 rd_valid  out  1  read data valid.
REQ-013 rd_data  out  16  read data.
REQ-014 ref_req  in  1  refresh due; level signal, held until ref_ack.
REQ-015 ref_ack  out  1  one-cycle pulse when the refresh command is accepted.
REQ-016 mem_cmd_valid / mem_cmd_we / mem_cmd_ref  out  1 each  command to sdramc: valid, write, refresh.
REQ-017 mem_cmd_addr  out  32, mem_wdata  out  16  command address and write data.
REQ-018 mem_cmd_ready  in  1  sdramc accepts the command this cycle.
REQ-019 mem_rvalid  in  1, mem_rdata  in  16  read return from sdramc.
REQ-020 grant  out  2  current state: 0 IDLE, 1 WR, 2 RD, 3 REF.

Function
REQ-021 States: IDLE, WR, RD, REF; grant is a registered copy of the state.
REQ-022 IDLE decision priority: ref_req -> REF; else wr_req & (wr_prio | ~rd_req | last_owner==RD) -> WR; else rd_req -> RD; else stay in IDLE.
REQ-023 Every burst and every refresh returns to IDLE for at least one cycle.
REQ-024 WR outputs (combinational): mem_cmd_valid=wr_req, mem_cmd_we=1, mem_cmd_addr=wr_addr, mem_wdata=wr_data, wr_valid=wr_req & mem_cmd_ready.
REQ-025 WR beat counter increments on each wr_valid.
REQ-026 WR exits to IDLE after the BURST_LEN-th accepted beat, or on any cycle with wr_req=0.
REQ-027 RD: mem_cmd_valid=rd_req & (cmd_cnt<BURST_LEN), mem_cmd_we=0, mem_cmd_addr=rd_addr.
REQ-028 RD: rd_cmd_ack = mem_cmd_valid & mem_cmd_ready; cmd_cnt increments on each rd_cmd_ack.
REQ-029 Outstanding counter: +1 on rd_cmd_ack, -1 on mem_rvalid, unchanged when both occur in the same cycle.
REQ-030 RD exits to IDLE only when outstanding==0 and (cmd_cnt==BURST_LEN or rd_req==0).
REQ-031 rd_valid = mem_rvalid & (state==RD); rd_data = mem_rdata; mem_rvalid in any other state is dropped.
REQ-032 REF: mem_cmd_valid=1, mem_cmd_ref=1. On mem_cmd_ready, registered ref_ack=1 for exactly one cycle, then IDLE.
REQ-033 mem_cmd_ref=0 outside REF; mem_cmd_we=0 outside WR.
REQ-034 All mem_* command outputs are 0 in IDLE.
REQ-035 mem_cmd_ready=0 stalls the current state; no counter advances.
REQ-036 ref_req asserted mid-burst is not serviced until the burst ends; worst-case wait is one full burst plus outstanding drain.
REQ-037 last_owner updates when leaving WR (to WR) or RD (to RD); REF does not change it.
REQ-038 Beat counter and cmd_cnt clear on entry to IDLE.
REQ-039 Counter widths: log2(BURST_LEN)+1 bits; no wrap-around is possible within legal parameter values.

Reset
REQ-040 sdram_rst=1 at a clock edge forces: state IDLE, grant=0, all counters 0, last_owner=RD, all outputs 0 on the following cycle, including mid-burst.
REQ-041 Outstanding reads are abandoned at reset; returns after reset are dropped per REQ-031.

Verification (BURST_LEN=4)
REQ-042 Bench scenario: wr_req held 1, rd_req=0, mem_cmd_ready=1 -> grant 1 for exactly 4 cycles, 4 wr_valid pulses, 1 IDLE cycle, then WR again.
REQ-043 Bench scenario: wr_req=rd_req=1, wr_prio=0 -> grant sequence WR, IDLE, RD, IDLE, WR (alternation); with wr_prio=1 -> RD never granted.
REQ-044 Bench scenario: RD with read latency 3 and rd_req held 1 -> 4 rd_cmd_ack, 4 rd_valid, grant stays 2 until the 4th mem_rvalid.
REQ-045 Bench scenario: ref_req rises during the 2nd WR beat -> WR completes 4 beats, IDLE, REF; ref_ack is a single pulse; next grant is WR or RD.
REQ-046 Bench scenario: mem_cmd_ready=0 for 5 cycles mid-WR -> wr_valid=0 throughout, beat count preserved, burst still 4 beats.
REQ-047 Bench scenario: sdram_rst pulsed with 2 reads outstanding -> next cycle grant=0 and all outputs 0; late mem_rvalid yields no rd_valid.
